// File: rtl/io_bus_arbiter_if.sv
// Bundle of requester-side handshake signals and the mmio register port shared by
// io_bus_arbiter. The slave modport is the arbiter's view; master is the requester/mmio side.
interface io_bus_arbiter_if #(
  parameter int unsigned N_REQ = 2
) ();

  // Requester request channel (packed per requester)
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_addr;
  logic [N_REQ*32-1:0] req_wdata;
  logic [N_REQ-1:0]    req_rw;
  logic [N_REQ*2-1:0]  req_dw;

  // Response channel; rdata/err are shared, rsp_valid selects the owner
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;

  // mmio register port
  logic [31:0]         io_addr;
  logic [31:0]         io_wdata;
  logic                io_mem_rw;
  logic                io_en;
  logic [1:0]          io_dw;
  logic [31:0]         io_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_rw, req_dw, rsp_ready, io_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output io_addr, io_wdata, io_mem_rw, io_en, io_dw
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_rw, req_dw, rsp_ready, io_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  io_addr, io_wdata, io_mem_rw, io_en, io_dw
  );

endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the single mmio register port between N_REQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, or IDLE -> RESP for accesses
// the mmio read/write address split would silently drop.
module io_bus_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter logic [31:0] IO_BASE    = 32'h0001_0000,
  parameter logic [31:0] IO_WR_BASE = IO_BASE + (IO_BASE >> 1)
) (
  input  logic            clk,
  input  logic            rst,
  io_bus_arbiter_if.slave bus,
  output logic            busy
);

  // N_REQ is limited to 2..4, so the index never needs more than 2 bits
  localparam int unsigned IDX_W = (N_REQ > 2) ? 2 : 1;

  localparam logic [1:0] DB = 2'd0;
  localparam logic [1:0] DH = 2'd1;
  localparam logic [1:0] DW = 2'd2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  idx_t        ptr_q, ptr_d;
  idx_t        grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [1:0]  dw_q, dw_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        win_found;
  idx_t        win_idx;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_rw;
  logic [1:0]  win_dw;
  logic        win_legal;
  int unsigned cand;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!win_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_addr  = bus.req_addr[win_idx*32 +: 32];
  assign win_wdata = bus.req_wdata[win_idx*32 +: 32];
  assign win_rw    = bus.req_rw[win_idx];
  assign win_dw    = bus.req_dw[win_idx*2 +: 2];

  // Legality of the request being accepted. Evaluating it on the winner's fields is the same
  // as checking the latched copy, and lets an illegal access reach RESP one cycle after accept.
  always_comb begin
    win_legal = 1'b1;
    if (win_addr < IO_BASE) begin
      win_legal = 1'b0;
    end
    if (!win_rw && (win_addr >= IO_WR_BASE)) begin
      win_legal = 1'b0;
    end
    if (win_rw && (win_addr < IO_WR_BASE)) begin
      win_legal = 1'b0;
    end
    if ((win_dw == DH) && win_addr[0]) begin
      win_legal = 1'b0;
    end
    if ((win_dw == DW) && (win_addr[1:0] != 2'b00)) begin
      win_legal = 1'b0;
    end
  end

  // Next-state and request handshake
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rw_d          = rw_q;
    dw_d          = dw_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.req_ready = '0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          bus.req_ready[win_idx] = 1'b1;
          ptr_d   = win_idx;
          grant_d = win_idx;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          rw_d    = win_rw;
          dw_d    = win_dw;
          rdata_d = '0;
          err_d   = !win_legal;
          state_d = win_legal ? StIssue : StResp;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // mmio registers its read data, so it is valid during this cycle
        rdata_d = rw_q ? 32'h0 : bus.io_rdata;
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready[grant_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      dw_q    <= DW;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      dw_q    <= dw_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state; io_* simply hold outside ISSUE, io_en qualifies them
  always_comb begin
    bus.io_addr   = addr_q;
    bus.io_wdata  = wdata_q;
    bus.io_mem_rw = rw_q;
    bus.io_dw     = dw_q;
    bus.io_en     = (state_q == StIssue);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.rsp_valid = '0;
    if (state_q == StResp) begin
      bus.rsp_valid[grant_q] = 1'b1;
    end
    busy = (state_q != StIdle);
  end

  ap_one_ready: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  ap_one_rsp:   assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rsp_valid));
  ap_en_resp:   assert property (@(posedge clk) disable iff (rst)
                                 !(bus.io_en && (bus.rsp_valid != '0)));

endmodule

// File: tb/tb_io_bus_arbiter.sv
`timescale 1ns/1ps
module tb_io_bus_arbiter;

  localparam int unsigned N          = 2;
  localparam logic [31:0] IO_BASE    = 32'h0001_0000;
  localparam logic [31:0] IO_WR_BASE = 32'h0001_8000;
  localparam logic [1:0]  DB = 2'd0;
  localparam logic [1:0]  DH = 2'd1;
  localparam logic [1:0]  DW = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  // mmio read-data override for directed tests
  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  io_bus_arbiter_if #(.N_REQ(N)) bus ();

  io_bus_arbiter #(
    .N_REQ      (N),
    .IO_BASE    (IO_BASE),
    .IO_WR_BASE (IO_WR_BASE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event never seen, expected within bound at %0t", name, $time);
  endtask

  // mmio stub contents: address hash, masked to the access width as mmio does
  function automatic logic [31:0] mmio_val(input logic [31:0] a, input logic [1:0] dw);
    logic [31:0] raw;
    raw = ovr_en ? ovr_val : ((a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C);
    case (dw)
      DB:      return raw & 32'h0000_00FF;
      DH:      return raw & 32'h0000_FFFF;
      default: return raw;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic rw, input logic [1:0] dw);
    bit region_ok;
    region_ok = rw ? (a >= IO_WR_BASE) : (a < IO_WR_BASE);
    return (a >= IO_BASE) && region_ok && !((dw == DH) && a[0]) &&
           !((dw == DW) && (a[1:0] != 2'b00));
  endfunction

  // Registered mmio read port
  always @(posedge clk) begin
    if (rst) bus.io_rdata <= 32'h0;
    else if (bus.io_en && !bus.io_mem_rw) bus.io_rdata <= mmio_val(bus.io_addr, bus.io_dw);
  end

  // Transaction-level reference: who is served, and how many cycles since the accept edge
  int          m_ptr = N - 1;
  int          m_grant = 0;
  int          m_age = 0;
  bit          m_busy = 1'b0;
  bit          m_legal = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_rw;
  logic [1:0]  m_dw;

  always @(negedge clk) begin
    int         win;
    bit         in_rsp, exp_en;
    logic [N-1:0] exp_ready, exp_rsp;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = N - 1;
    end else begin
      win = -1;
      if (!m_busy) begin
        for (int i = 1; i <= int'(N); i++) begin
          if (win < 0 && bus.req_valid[(m_ptr + i) % N]) win = (m_ptr + i) % N;
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      in_rsp  = m_busy && (m_legal ? (m_age >= 3) : (m_age >= 1));
      exp_en  = m_busy && m_legal && (m_age == 1);
      exp_rsp = '0;
      if (in_rsp) exp_rsp[m_grant] = 1'b1;

      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
      check("busy", 32'(busy), 32'(m_busy));
      check("io_en", 32'(bus.io_en), 32'(exp_en));
      if (in_rsp) begin
        check("rsp_rdata", bus.rsp_rdata, m_rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(!m_legal));
      end
      if (exp_en) begin
        check("io_addr", bus.io_addr, m_addr);
        check("io_mem_rw", 32'(bus.io_mem_rw), 32'(m_rw));
        check("io_dw", 32'(bus.io_dw), 32'(m_dw));
        if (m_rw) check("io_wdata", bus.io_wdata, m_wdata);
      end

      if (!m_busy) begin
        if (win >= 0) begin
          m_grant = win;
          m_addr  = bus.req_addr[win*32 +: 32];
          m_wdata = bus.req_wdata[win*32 +: 32];
          m_rw    = bus.req_rw[win];
          m_dw    = bus.req_dw[win*2 +: 2];
          m_legal = legal(m_addr, m_rw, m_dw);
          m_rdata = (m_legal && !m_rw) ? mmio_val(m_addr, m_dw) : 32'h0;
          m_busy  = 1'b1;
          m_age   = 1;
          m_ptr   = win;
        end
      end else if (in_rsp) begin
        if (bus.rsp_ready[m_grant]) m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, input logic [1:0] dw);
    bus.req_addr[r*32 +: 32]  = a;
    bus.req_wdata[r*32 +: 32] = wd;
    bus.req_rw[r]             = rw;
    bus.req_dw[r*2 +: 2]      = dw;
    bus.req_valid[r]          = 1'b1;
  endtask

  // One request with rsp_ready high; reports latency from the accept edge and the io cycle seen
  task automatic run_txn(input int r, input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, input logic [1:0] dw,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int en_cnt, output logic [31:0] en_wdata,
                         output logic en_rw, output logic [1:0] en_dw);
    int n;
    lat = 0; rdata = 32'hx; err = 1'bx; en_cnt = 0; en_wdata = 32'h0; en_rw = 1'b0; en_dw = 2'd3;
    set_req(r, a, wd, rw, dw);
    #1;
    n = 0;
    while (!bus.req_ready[r] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready[r]) begin
      fail_timeout("accept");
      bus.req_valid[r] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    lat = 1;
    while (!bus.rsp_valid[r] && lat < 20) begin
      if (bus.io_en) begin
        en_cnt++; en_wdata = bus.io_wdata; en_rw = bus.io_mem_rw; en_dw = bus.io_dw;
      end
      @(posedge clk); #1; lat++;
    end
    if (!bus.rsp_valid[r]) begin
      fail_timeout("response");
      return;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, en_cnt, n, cyc, nrsp, multi;
    logic [31:0] rd, en_wd, rd0;
    logic        er, en_rw;
    logic [1:0]  en_dw;
    int          grants[$];
    logic [31:0] bad_addr[4];
    logic        bad_rw[4];
    logic [1:0]  bad_dw[4];

    bus.req_valid = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_rw = '0;
    bus.req_dw = '0; bus.rsp_ready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_io_en", 32'(bus.io_en), 32'h0);
    check("reset_io_dw", 32'(bus.io_dw), 32'(DW));
    check("reset_io_addr", bus.io_addr, 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = '1;
    @(posedge clk); #1;

    // Single read
    ovr_en = 1'b1; ovr_val = 32'h1234_5678;
    run_txn(0, IO_BASE + 4, 32'h0, 1'b0, DW, lat, rd, er, en_cnt, en_wd, en_rw, en_dw);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rd, 32'h1234_5678);
    check("rd_err", 32'(er), 32'h0);
    check("rd_io_en_cycles", 32'(en_cnt), 32'd1);
    ovr_en = 1'b0;

    // Byte write from requester 1
    run_txn(1, IO_WR_BASE, 32'h0000_00A5, 1'b1, DB, lat, rd, er, en_cnt, en_wd, en_rw, en_dw);
    check("wr_io_en_cycles", 32'(en_cnt), 32'd1);
    check("wr_io_mem_rw", 32'(en_rw), 32'h1);
    check("wr_io_wdata", en_wd, 32'h0000_00A5);
    check("wr_io_dw", 32'(en_dw), 32'(DB));
    check("wr_err", 32'(er), 32'h0);
    check("wr_rdata", rd, 32'h0);
    check("wr_latency", 32'(lat), 32'd3);

    // Contention: both valid for four transactions
    set_req(0, IO_BASE + 8, 32'h0, 1'b0, DW);
    set_req(1, IO_BASE + 12, 32'h0, 1'b0, DW);
    #1;
    cyc = 0; nrsp = 0; multi = 0;
    while (nrsp < 4 && cyc < 40) begin
      if (bus.req_ready != '0) grants.push_back(bus.req_ready[1] ? 1 : 0);
      if (bus.rsp_valid != '0) nrsp++;
      if (!$onehot0(bus.rsp_valid)) multi++;
      @(posedge clk); #1; cyc++;
      if (grants.size() >= 4) bus.req_valid = '0;
    end
    bus.req_valid = '0;
    check("cont_cycles", 32'(cyc), 32'd16);
    check("cont_grant_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grants.size()) check("cont_grant_order", 32'(grants[k]), 32'(k % 2));
    end
    check("cont_multi_rsp", 32'(multi), 32'h0);

    // Illegal accesses
    bad_addr[0] = IO_WR_BASE;  bad_rw[0] = 1'b0; bad_dw[0] = DW;
    bad_addr[1] = IO_BASE;     bad_rw[1] = 1'b1; bad_dw[1] = DW;
    bad_addr[2] = IO_BASE + 2; bad_rw[2] = 1'b0; bad_dw[2] = DW;
    bad_addr[3] = IO_BASE - 4; bad_rw[3] = 1'b0; bad_dw[3] = DB;
    for (int k = 0; k < 4; k++) begin
      run_txn(k % 2, bad_addr[k], 32'hDEAD_BEEF, bad_rw[k], bad_dw[k],
              lat, rd, er, en_cnt, en_wd, en_rw, en_dw);
      check("ill_latency", 32'(lat), 32'd1);
      check("ill_err", 32'(er), 32'h1);
      check("ill_rdata", rd, 32'h0);
      check("ill_io_en", 32'(en_cnt), 32'h0);
    end

    // Backpressure on requester 0 while requester 1 waits
    bus.rsp_ready = 2'b10;
    set_req(0, IO_BASE + 16, 32'h0, 1'b0, DW);
    #1;
    n = 0;
    while (!bus.req_ready[0] && n < 10) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready[0]) fail_timeout("bp_accept");
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    set_req(1, IO_BASE + 20, 32'h0, 1'b0, DH);
    n = 0;
    while (!bus.rsp_valid[0] && n < 10) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid[0]) fail_timeout("bp_response");
    rd0 = bus.rsp_rdata;
    check("bp_first_rdata", rd0, mmio_val(IO_BASE + 16, DW));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_rdata_stable", bus.rsp_rdata, rd0);
      check("bp_busy", 32'(busy), 32'h1);
      check("bp_no_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    check("bp_req1_granted", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    n = 0;
    while (!bus.rsp_valid[1] && n < 10) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid[1]) fail_timeout("bp_req1_response");
    @(posedge clk); #1;

    // Reset during ISSUE; pointer would otherwise favour requester 1 next
    set_req(0, IO_BASE + 24, 32'h0, 1'b0, DW);
    #1;
    n = 0;
    while (!bus.req_ready[0] && n < 10) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready[0]) fail_timeout("rst_accept");
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    check("rst_pre_io_en", 32'(bus.io_en), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_io_en", 32'(bus.io_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, IO_BASE + 28, 32'h0, 1'b0, DW);
    set_req(1, IO_BASE + 32, 32'h0, 1'b0, DW);
    #1;
    check("rst_req0_first", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < int'(N); r++) begin
        logic [31:0] a;
        logic        rw;
        int          sel;
        sel = $urandom_range(0, 5);
        case (sel)
          0:       begin a = IO_BASE - 4 * $urandom_range(1, 4); rw = $urandom_range(0, 1); end
          1, 2:    begin a = IO_BASE + $urandom_range(0, 255); rw = ($urandom_range(0, 3) == 0); end
          3, 4:    begin a = IO_WR_BASE + $urandom_range(0, 255); rw = ($urandom_range(0, 3) != 0); end
          default: begin a = IO_WR_BASE - $urandom_range(1, 4); rw = $urandom_range(0, 1); end
        endcase
        bus.req_addr[r*32 +: 32]  = a;
        bus.req_wdata[r*32 +: 32] = $urandom;
        bus.req_rw[r]             = rw;
        bus.req_dw[r*2 +: 2]      = 2'($urandom_range(0, 2));
        bus.req_valid[r]          = ($urandom_range(0, 2) != 0);
        bus.rsp_ready[r]          = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end

    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (10) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO register port (the mmio block) between N_REQ requesters, e.g. core load/store unit and debug/DMA port.
- Round-robin arbitration; one transaction in flight.
- Drives addr/wdata/mem_rw/io_en/dw into mmio, captures its registered io_read and returns it to the winner over a valid/ready response channel.
- Rejects accesses that the mmio read/write split would silently drop.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- IO_BASE, IO_START (defs.svh constant), start of IO space.
- IO_WR_BASE, IO_START + IO_START/2, first write-region address; reads only below it, writes only at or above it.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  one-hot accept pulse.
- req_addr  in  N_REQ*32  packed byte addresses.
- req_wdata  in  N_REQ*32  packed write data.
- req_rw  in  N_REQ  0 = read, 1 = write.
- req_dw  in  N_REQ x data_width  access width DB/DH/DW.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp_ready  in  N_REQ  response accept.
- rsp_rdata  out  32  read data, shared by all requesters.
- rsp_err  out  1  response is an error; no IO access was made.
- io_addr  out  32  to mmio addr.
- io_wdata  out  32  to mmio wdata.
- io_mem_rw  out  1  to mmio mem_rw.
- io_en  out  1  to mmio io_en.
- io_dw  out  data_width  to mmio dw.
- io_rdata  in  32  from mmio io_read; registered, valid the cycle after the io_en edge.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate):
  - State IDLE; all outputs 0; io_dw = DW.
  - Last-grant pointer = N_REQ-1, so requester 0 has highest priority first.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Error path: IDLE -> RESP.
- IDLE:
  - Winner = first requester with req_valid, scanning from pointer+1 modulo N_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle; handshake completes at that edge.
  - Latch addr, wdata, rw, dw and grant index; update pointer to winner.
  - No valid request: stay in IDLE, all req_ready = 0.
- Legality check, on the latched request:
  - Illegal if addr < IO_BASE.
  - Illegal if a read has addr >= IO_WR_BASE.
  - Illegal if a write has addr < IO_WR_BASE.
  - Illegal if a DH access is not 2-byte aligned, or a DW access is not 4-byte aligned.
  - Illegal -> next state RESP with err = 1, rdata = 0. io_en is never asserted.
- ISSUE (exactly 1 cycle):
  - io_en = 1; io_* driven from latched registers.
  - mmio samples at the closing edge.
- WAIT (exactly 1 cycle), io_en = 0:
  - Read: at the closing edge latch rsp_rdata = io_rdata; mmio has already masked it to dw.
  - Write: rsp_rdata = 0.
- RESP:
  - rsp_valid[grant] = 1; rsp_rdata and rsp_err held stable.
  - Leave to IDLE on the edge where rsp_ready[grant] = 1.
  - Stall indefinitely otherwise. No new grant while in RESP.
- Latency and throughput:
  - Legal access: accept edge to rsp_valid = 3 cycles. Error: 1 cycle.
  - Peak rate: one legal transaction per 4 cycles with rsp_ready tied high.
- io_* hold their last values outside ISSUE; only io_en qualifies them.
- A requester may hold req_valid through its own RESP. It is re-arbitrated only on return to IDLE, behind other requesters by round-robin order.
- Simultaneous req_valid: round-robin decides. At most one req_ready and one rsp_valid bit are set at any time.
- rst asserted in any state:
  - Transaction is abandoned; no response is given.
  - If rst hits during ISSUE, io_en drops immediately; the mmio write may or may not occur.

Test Plan:
- Single read: req0 reads IO_BASE+4, mmio returns 0x1234_5678 -> req_ready[0] at cycle 0, io_en high cycle 1 only, rsp_valid[0] cycle 3 with rdata 0x1234_5678, err 0.
- Write then read-back: req1 writes 0xA5 (DB) to IO_WR_BASE -> one io_en cycle with io_mem_rw = 1, io_wdata = 0xA5, io_dw = DB; response err 0, rdata 0.
- Contention: both req_valid held high for 4 transactions, rsp_ready = 1 -> grants 0,1,0,1; 16 cycles total; never two bits of rsp_valid set.
- Illegal accesses: read at IO_WR_BASE, write at IO_BASE, DW at IO_BASE+2, any access at IO_BASE-4 -> each gives rsp_valid 1 cycle after accept with err 1, rdata 0, io_en never high.
- Backpressure: rsp_ready[0] low for 5 cycles while req1 is valid -> rsp_valid[0] and rdata stable, busy = 1, req_ready[1] = 0. req1 is granted the cycle after rsp_ready[0] rises.
- Reset mid-operation: assert rst in ISSUE -> io_en, busy, rsp_valid = 0 in the same cycle. After release, req0 wins first.
